// File: rtl/logic_unit_mc.sv
// logic_unit_mc: multi-cycle logic / branch-compare / bit-serial shift unit.
// Logic, branch and illegal ops finish in one cycle. Shifts by N>=1 walk one
// bit per clock, then publish the result. Result/zero are registered and hold
// between done pulses.
module logic_unit_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       AluOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             zero
);

  // Operation encodings
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_BLT  = 4'b0110;
  localparam logic [3:0] OP_BGE  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_BLTU = 4'b1011;

  // Shift kinds; these are exactly AluOp[1:0] of the three shift ops
  localparam logic [1:0] SK_LL = 2'b00;
  localparam logic [1:0] SK_RL = 2'b01;
  localparam logic [1:0] SK_RA = 2'b10;

  localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // One-bit shift step of the given kind
  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] kind,
                                                 input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] res;
    case (kind)
      SK_LL:   res = {val[WIDTH-2:0], 1'b0};
      SK_RL:   res = {1'b0, val[WIDTH-1:1]};
      SK_RA:   res = {val[WIDTH-1], val[WIDTH-1:1]};
      default: res = val;
    endcase
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic [1:0]       kind_q,  kind_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] imm_res_s;
  logic             imm_zero_s;
  logic             is_shift_s;
  logic [SHW-1:0]   sh_amt_s;
  logic [WIDTH-1:0] step_s;

  assign sh_amt_s = B[SHW-1:0];
  assign step_s   = shift_one(kind_q, shreg_q);

  // Single-cycle outcome of the op presented at the inputs (N=0 shifts pass A)
  always_comb begin
    imm_res_s  = '0;
    imm_zero_s = 1'b0;
    is_shift_s = 1'b0;
    case (AluOp)
      OP_AND: begin
        imm_res_s  = A & B;
        imm_zero_s = ((A & B) == '0);
      end
      OP_OR: begin
        imm_res_s  = A | B;
        imm_zero_s = ((A | B) == '0);
      end
      OP_XOR: begin
        imm_res_s  = A ^ B;
        imm_zero_s = ((A ^ B) == '0);
      end
      OP_NOR: begin
        imm_res_s  = ~(A | B);
        imm_zero_s = (~(A | B) == '0);
      end
      OP_BEQ:  imm_zero_s = (A == B);
      OP_BNE:  imm_zero_s = (A != B);
      OP_BLT:  imm_zero_s = ($signed(A) < $signed(B));
      OP_BGE:  imm_zero_s = !($signed(A) < $signed(B));
      OP_BLTU: imm_zero_s = (A < B);
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift_s = 1'b1;
        imm_res_s  = A;
        imm_zero_s = (A == '0);
      end
      default: begin
        imm_res_s  = '0;
        imm_zero_s = 1'b0;
      end
    endcase
  end

  // FSM next-state, shift datapath and result update
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_s && (sh_amt_s != CNT_ZERO)) begin
            state_d = ST_SHIFT;
            shreg_d = A;
            cnt_d   = sh_amt_s;
            kind_d  = AluOp[1:0];
          end else begin
            result_d = imm_res_s;
            zero_d   = imm_zero_s;
            done_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_d = step_s;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = ST_IDLE;
          result_d = step_s;
          zero_d   = (step_s == '0);
          done_d   = 1'b1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset aborts any shift in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= CNT_ZERO;
      kind_q   <= SK_LL;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = done_q;
  assign Result = result_q;
  assign zero   = zero_q;

endmodule
